// File: rtl/beam_scan_if.sv
// Bus bundle for beam_scan_ctrl: sample stream in, index-RAM read port,
// and selected-sample stream out.
// master: the scan controller. slave: the surrounding datapath / RAM.
interface beam_scan_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 10
);
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic [ADDR_W-1:0] tbl_addr;
    logic              tbl_rden;
    logic [IDX_W-1:0]  tbl_q;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;

    modport master (
        input  src_valid, src_data, tbl_q,
        output src_ready, tbl_addr, tbl_rden, sel_valid, sel_data
    );

    modport slave (
        output src_valid, src_data, tbl_q,
        input  src_ready, tbl_addr, tbl_rden, sel_valid, sel_data
    );
endinterface

// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: sequencer for the delay beamformer.
// Steps through N_BEAMS steering directions; for each beam it streams a
// window of SAMPLES samples, fetches the beam's delay-index table from the
// index RAM one entry at a time, and emits the sample whose index equals the
// current entry. Entries that are passed or never reached set the sticky
// miss flag.
// Optional feature: define SCAN_LOOP_EN for continuous scanning (after the
// last beam, done pulses and the scan restarts at beam 0 instead of idling).
module beam_scan_ctrl #(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16,
    parameter int ADDR_W  = 10,
    parameter int N_BEAMS = 8,
    parameter int ENTRIES = 16,
    parameter int SAMPLES = 1024,
    parameter int TBL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    beam_scan_if.master bus,
    output logic [7:0]  beam_id,
    output logic        busy,
    output logic        done,
    output logic        miss
);
    localparam int ENT_W = $clog2(ENTRIES) + 1;
    localparam int LAT_W = $clog2(TBL_LAT) + 1;

    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, NEXT} state_t;

    state_t            state, state_nxt;
    logic [LAT_W-1:0]  prime_cnt, prime_cnt_nxt;
    logic [IDX_W-1:0]  samp_cnt, samp_cnt_nxt;
    logic [ENT_W-1:0]  entry, entry_nxt;
    logic [7:0]        beam, beam_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic              sel_valid_r, sel_valid_nxt;
    logic [DATA_W-1:0] sel_data_r, sel_data_nxt;
    logic              done_nxt, miss_nxt;

    logic              ready;
    logic              hs;
    logic              hit;
    logic              passed;
    logic              consume;
    logic              last_samp;
    logic              last_entry;
    logic              last_beam;
    logic [ADDR_W-1:0] next_base;

    // Samples are only taken while walking a window; the RAM read stays
    // enabled through RUN so its output keeps tracking the current entry.
    assign ready        = (state == RUN) || (state == DRAIN);
    assign bus.src_ready = ready;
    assign bus.tbl_rden  = (state == PRIME) || (state == RUN);
    assign bus.tbl_addr  = addr;
    assign bus.sel_valid = sel_valid_r;
    assign bus.sel_data  = sel_data_r;
    assign beam_id       = beam;
    assign busy          = (state != IDLE);

    assign hs         = bus.src_valid && ready;
    assign hit        = (samp_cnt == bus.tbl_q);
    assign passed     = (samp_cnt > bus.tbl_q);
    assign consume    = hit || passed;
    assign last_samp  = (samp_cnt == IDX_W'(SAMPLES - 1));
    assign last_entry = (entry == ENT_W'(ENTRIES - 1));
    assign last_beam  = (beam == 8'(N_BEAMS - 1));
    assign next_base  = ADDR_W'((32'(beam) + 32'd1) * 32'(ENTRIES));

    // Next-state and next-value logic for the scan FSM and its counters.
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        samp_cnt_nxt  = samp_cnt;
        entry_nxt     = entry;
        beam_nxt      = beam;
        addr_nxt      = addr;
        sel_valid_nxt = 1'b0;
        sel_data_nxt  = sel_data_r;
        done_nxt      = 1'b0;
        miss_nxt      = miss;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = PRIME;
                    prime_cnt_nxt = '0;
                    samp_cnt_nxt  = '0;
                    entry_nxt     = '0;
                    beam_nxt      = '0;
                    addr_nxt      = '0;
                    miss_nxt      = 1'b0;
                end
            end
            PRIME: begin
                // Wait out the RAM latency for the freshly loaded address.
                if (prime_cnt == LAT_W'(TBL_LAT - 1)) begin
                    state_nxt     = RUN;
                    prime_cnt_nxt = '0;
                end else begin
                    prime_cnt_nxt = prime_cnt + 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    samp_cnt_nxt = samp_cnt + 1'b1;
                    if (hit) begin
                        sel_valid_nxt = 1'b1;
                        sel_data_nxt  = bus.src_data;
                    end else if (passed) begin
                        miss_nxt = 1'b1;
                    end
                    if (consume) begin
                        entry_nxt = entry + 1'b1;
                        addr_nxt  = addr + 1'b1;
                    end
                    // The window closes on its last sample regardless of
                    // table progress; any entry still pending is a miss.
                    if (last_samp) begin
                        state_nxt = NEXT;
                        if (!(consume && last_entry)) begin
                            miss_nxt = 1'b1;
                        end
                    end else if (consume) begin
                        state_nxt = last_entry ? DRAIN : PRIME;
                    end
                end
            end
            DRAIN: begin
                if (hs) begin
                    samp_cnt_nxt = samp_cnt + 1'b1;
                    if (last_samp) begin
                        state_nxt = NEXT;
                    end
                end
            end
            NEXT: begin
                if (last_beam) begin
                    done_nxt = 1'b1;
`ifdef SCAN_LOOP_EN
                    state_nxt     = PRIME;
                    prime_cnt_nxt = '0;
                    samp_cnt_nxt  = '0;
                    entry_nxt     = '0;
                    beam_nxt      = '0;
                    addr_nxt      = '0;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    state_nxt     = PRIME;
                    prime_cnt_nxt = '0;
                    samp_cnt_nxt  = '0;
                    entry_nxt     = '0;
                    beam_nxt      = beam + 1'b1;
                    addr_nxt      = next_base;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start; the
        // beam in flight is dropped and the miss history is kept.
        if (abort) begin
            state_nxt     = IDLE;
            prime_cnt_nxt = '0;
            sel_valid_nxt = 1'b0;
            done_nxt      = 1'b0;
            miss_nxt      = miss;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prime_cnt   <= '0;
            samp_cnt    <= '0;
            entry       <= '0;
            beam        <= '0;
            addr        <= '0;
            sel_valid_r <= 1'b0;
            sel_data_r  <= '0;
            done        <= 1'b0;
            miss        <= 1'b0;
        end else begin
            state       <= state_nxt;
            prime_cnt   <= prime_cnt_nxt;
            samp_cnt    <= samp_cnt_nxt;
            entry       <= entry_nxt;
            beam        <= beam_nxt;
            addr        <= addr_nxt;
            sel_valid_r <= sel_valid_nxt;
            sel_data_r  <= sel_data_nxt;
            done        <= done_nxt;
            miss        <= miss_nxt;
        end
    end
endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Testbench for beam_scan_ctrl with a small configuration
// (2 beams, 4 entries, 16 samples, RAM latency 2).
`timescale 1ns/1ps
module tb_beam_scan_ctrl;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 16;
    localparam int ADDR_W  = 10;
    localparam int N_BEAMS = 2;
    localparam int ENTRIES = 4;
    localparam int SAMPLES = 16;
    localparam int TBL_LAT = 2;
    localparam int TOTAL   = N_BEAMS * SAMPLES;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] beam_id;
    logic       busy;
    logic       done;
    logic       miss;

    int n_checks = 0;
    int n_fail   = 0;

    beam_scan_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    beam_scan_ctrl #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .N_BEAMS(N_BEAMS),
        .ENTRIES(ENTRIES), .SAMPLES(SAMPLES), .TBL_LAT(TBL_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bus(bus),
        .beam_id(beam_id), .busy(busy), .done(done), .miss(miss)
    );

    always #5 clk = ~clk;

    // Index RAM model with a two-cycle read pipeline.
    logic [IDX_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [IDX_W-1:0] q_p1 = '0;
    logic [IDX_W-1:0] q_p2 = '0;
    always @(posedge clk) begin
        q_p1 <= mem[bus.tbl_addr];
        q_p2 <= q_p1;
    end
    assign bus.tbl_q = q_p2;

    // Reference data for one scan.
    logic [DATA_W-1:0] data [0:TOTAL-1];
    bit                match [0:TOTAL-1];
    logic [DATA_W-1:0] exp_sel [$];
    bit                exp_miss;
    int                exp_rlow;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic set_table(input int b, input int e0, input int e1, input int e2, input int e3);
        mem[b*ENTRIES+0] = IDX_W'(e0);
        mem[b*ENTRIES+1] = IDX_W'(e1);
        mem[b*ENTRIES+2] = IDX_W'(e2);
        mem[b*ENTRIES+3] = IDX_W'(e3);
    endtask

    task automatic rand_tables();
        for (int b = 0; b < N_BEAMS; b++) begin
            int v;
            v = $urandom_range(0, 3);
            for (int e = 0; e < ENTRIES; e++) begin
                if ($urandom_range(0, 4) == 0) mem[b*ENTRIES+e] = IDX_W'($urandom_range(0, 19));
                else mem[b*ENTRIES+e] = IDX_W'(v);
                v = v + $urandom_range(1, 5);
            end
        end
    endtask

    // Sample-level model: walk each window, consuming at most one table
    // entry per sample; count how many table fetches each beam needs.
    task automatic build_model();
        exp_sel.delete();
        exp_miss = 1'b0;
        exp_rlow = 0;
        for (int k = 0; k < TOTAL; k++) data[k] = $urandom;
        for (int b = 0; b < N_BEAMS; b++) begin
            int e;
            int primes;
            e = 0;
            primes = 1;
            for (int s = 0; s < SAMPLES; s++) begin
                int k;
                int t;
                k = b*SAMPLES + s;
                match[k] = 1'b0;
                if (e < ENTRIES) begin
                    t = int'(mem[b*ENTRIES+e]);
                    if (s == t) begin
                        match[k] = 1'b1;
                        exp_sel.push_back(data[k]);
                    end else if (s > t) begin
                        exp_miss = 1'b1;
                    end
                    if (s >= t) begin
                        e++;
                        if (e < ENTRIES && s != SAMPLES-1) primes++;
                    end
                end
            end
            if (e < ENTRIES) exp_miss = 1'b1;
            exp_rlow += primes*TBL_LAT + 1;
        end
    endtask

    task automatic abort_now();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("busy_after_abort", busy, 0);
    endtask

    // vmode: 0 = valid held, 1 = valid toggling, 2 = random valid.
    task automatic run_scan(input int vmode, input int abort_at, input bit stray);
        int   k, cyc, dones, rlow;
        bit   pend, fin, aborted;
        logic held_miss;
        build_model();
        @(negedge clk);
        start = 1'b1;
        bus.src_valid = 1'b0;
        k = 0; cyc = 0; dones = 0; rlow = 0;
        pend = 0; fin = 0; aborted = 0; held_miss = 1'b0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            check_eq("sel_valid", bus.sel_valid, pend);
            if (bus.sel_valid) begin
                if (exp_sel.size() == 0) check_eq("sel_extra", 1, 0);
                else check_eq("sel_data", bus.sel_data, exp_sel.pop_front());
            end
            if (done) begin
                dones++;
                check_eq("done_after_samples", k, TOTAL);
                fin = 1;
            end else if (busy && !bus.src_ready) begin
                rlow++;
            end
            if (aborted) begin
                check_eq("busy_after_abort", busy, 0);
                fin = 1;
            end
            pend = 0;
            bus.src_valid = 1'b0;
            if (!fin) begin
                if (abort_at >= 0 && k == abort_at) begin
                    abort = 1'b1;
                    aborted = 1;
                    held_miss = miss;
                end else if (k < TOTAL) begin
                    case (vmode)
                        0:       bus.src_valid = 1'b1;
                        1:       bus.src_valid = cyc[0];
                        default: bus.src_valid = 1'($urandom_range(0, 1));
                    endcase
                    bus.src_data = data[k];
                    if (stray && (cyc % 7) == 3) start = 1'b1;
                    if (bus.src_valid && bus.src_ready) begin
                        check_eq("beam_id", beam_id, k / SAMPLES);
                        pend = match[k];
                        k++;
                    end
                end
            end
        end
        start = 1'b0;
        bus.src_valid = 1'b0;
        if (!fin) check_eq("timeout", 0, 1);
        if (aborted) begin
            check_eq("miss_held", miss, held_miss);
            @(negedge clk);
            check_eq("no_done_after_abort", done, 0);
            check_eq("sel_valid_after_abort", bus.sel_valid, 0);
        end else begin
            check_eq("done_count", dones, 1);
            check_eq("sel_left", exp_sel.size(), 0);
            check_eq("miss", miss, exp_miss);
            check_eq("ready_low_cycles", rlow, exp_rlow);
`ifdef SCAN_LOOP_EN
            check_eq("busy_after_done", busy, 1);
            abort_now();
`else
            check_eq("busy_after_done", busy, 0);
            @(negedge clk);
            check_eq("done_single_pulse", done, 0);
`endif
        end
    endtask

    initial begin
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_miss", miss, 0);
        check_eq("rst_beam_id", beam_id, 0);
        check_eq("rst_sel_valid", bus.sel_valid, 0);
        check_eq("rst_sel_data", bus.sel_data, 0);
        check_eq("rst_tbl_addr", bus.tbl_addr, 0);
        check_eq("rst_tbl_rden", bus.tbl_rden, 0);
        check_eq("rst_src_ready", bus.src_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic scan, valid held.
        set_table(0, 1, 3, 7, 12);
        set_table(1, 0, 5, 6, 15);
        run_scan(0, -1, 0);

        // Repeated entry gets skipped.
        set_table(0, 2, 2, 9, 14);
        run_scan(0, -1, 0);

        // Entry beyond the window.
        set_table(0, 1, 3, 7, 20);
        run_scan(0, -1, 0);

        // Abort in beam 1, then a clean rescan.
        set_table(0, 1, 3, 7, 12);
        run_scan(0, SAMPLES + 5, 0);
        run_scan(0, -1, 0);

        // Toggling valid with stray start pulses.
        run_scan(1, -1, 1);

        // Random tables, random valid.
        for (int r = 0; r < 6; r++) begin
            rand_tables();
            run_scan(2, -1, 1'(r % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
